// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction fetch memory.
// No logic; state encoding and default NOP word only.
package inst_mem_pkg;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_LOAD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [15:0] FILL_WORD_DEF = 16'hFFFF;

endpackage

// File: rtl/inst_mem_ram.sv
// Synchronous 1W/1R instruction storage, DATA_W x 2**ADDR_W.
// Read data registered one cycle after re and held while re is low; no backpressure.
module inst_mem_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Contents are deliberately unreset; the owner fills them after reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/inst_fetch_mem.sv
// Instruction memory with power-up fill, load mode and 1-cycle fetch path.
// Fetch result one cycle after i_req; fetches accepted every cycle only while o_ready.
module inst_fetch_mem
   import inst_mem_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 8,
   parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEF),
   parameter int                END_ADDR  = (2**ADDR_W) - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_ld_en,
   input  logic              i_ld_we,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_req,
   input  logic [31:0]       i_dir,
   output logic [DATA_W-1:0] o_inst,
   output logic              o_valid,
   output logic              o_ready,
   output logic              o_done,
   output logic              o_err
);

   localparam int          DEPTH     = 2**ADDR_W;
   localparam logic [31:0] DIR_DEPTH = 32'(DEPTH);
   localparam logic [31:0] DIR_END   = 32'(END_ADDR);

   state_t              state;
   logic [ADDR_W-1:0]   fill_cnt;
   logic                valid_q;
   logic                err_q;
   logic                done_q;
   logic [DATA_W-1:0]   inst_hold;

   logic                fetch_go;
   logic                dir_oor;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;

   // A simultaneous load request takes priority and drops the fetch.
   assign fetch_go = (state == ST_RUN) && i_req && !i_ld_en;
   assign dir_oor  = (i_dir >= DIR_DEPTH);

   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = i_ld_addr;
      ram_wdata = i_ld_data;
      if (state == ST_INIT) begin
         ram_we    = 1'b1;
         ram_waddr = fill_cnt;
         ram_wdata = FILL_WORD;
      end else if (state == ST_LOAD) begin
         ram_we    = i_ld_we;
      end
   end

   inst_mem_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (fetch_go && !dir_oor),
      .raddr (i_dir[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_INIT;
         fill_cnt  <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         inst_hold <= FILL_WORD;
      end else begin
         valid_q   <= fetch_go;
         err_q     <= fetch_go && dir_oor;
         inst_hold <= o_inst;
         case (state)
            ST_INIT: begin
               fill_cnt <= fill_cnt + ADDR_W'(1);
               if (fill_cnt == {ADDR_W{1'b1}}) state <= ST_RUN;
            end
            ST_RUN: begin
               if (i_ld_en) begin
                  state  <= ST_LOAD;
                  done_q <= 1'b0;
               end else if (i_req && (i_dir == DIR_END)) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (!i_ld_en) state <= ST_RUN;
            end
            ST_DONE: begin
               if (i_ld_en) begin
                  state  <= ST_LOAD;
                  done_q <= 1'b0;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

   // Registered read data is only meaningful in the cycle after a fetch; otherwise hold.
   assign o_inst  = valid_q ? (err_q ? FILL_WORD : ram_rdata) : inst_hold;
   assign o_valid = valid_q;
   assign o_err   = err_q;
   assign o_done  = done_q;
   assign o_ready = (state == ST_RUN);

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem with a cycle-level reference model and literal checks.
module tb_inst_fetch_mem;

   localparam int M_INIT = 0, M_RUN = 1, M_LOAD = 2, M_DONE = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_ld_en, i_ld_we, i_req;
   logic [7:0]  i_ld_addr;
   logic [15:0] i_ld_data;
   logic [31:0] i_dir;
   logic [15:0] o_inst;
   logic        o_valid, o_ready, o_done, o_err;

   int n_chk  = 0;
   int n_fail = 0;

   inst_fetch_mem dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ld_en   (i_ld_en),
      .i_ld_we   (i_ld_we),
      .i_ld_addr (i_ld_addr),
      .i_ld_data (i_ld_data),
      .i_req     (i_req),
      .i_dir     (i_dir),
      .o_inst    (o_inst),
      .o_valid   (o_valid),
      .o_ready   (o_ready),
      .o_done    (o_done),
      .o_err     (o_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: behaviour expressed as modes, an init countdown and an array.
   int          mode      = M_INIT;
   int          init_left = 256;
   logic [15:0] mm [256];
   logic [15:0] e_inst    = 16'hFFFF;
   logic        e_valid   = 1'b0;
   logic        e_err     = 1'b0;
   logic        e_done    = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode = M_INIT; init_left = 256;
         e_inst = 16'hFFFF; e_valid = 0; e_err = 0; e_done = 0;
         for (int a = 0; a < 256; a++) mm[a] = 16'hFFFF;
      end else begin
         e_valid = 0; e_err = 0;
         case (mode)
            M_INIT: begin
               init_left--;
               if (init_left == 0) mode = M_RUN;
            end
            M_RUN: begin
               if (i_ld_en) mode = M_LOAD;
               else if (i_req) begin
                  e_valid = 1;
                  if (i_dir >= 256) begin e_inst = 16'hFFFF; e_err = 1; end
                  else e_inst = mm[i_dir[7:0]];
                  if (i_dir == 255) begin e_done = 1; mode = M_DONE; end
               end
            end
            M_LOAD: begin
               if (i_ld_we) mm[i_ld_addr] = i_ld_data;
               if (!i_ld_en) mode = M_RUN;
            end
            default: begin
               if (i_ld_en) begin mode = M_LOAD; e_done = 0; end
            end
         endcase
      end
   end

   always @(negedge clk) begin
      chk("m_inst",  32'(o_inst),  32'(e_inst));
      chk("m_valid", 32'(o_valid), 32'(e_valid));
      chk("m_err",   32'(o_err),   32'(e_err));
      chk("m_done",  32'(o_done),  32'(e_done));
      chk("m_ready", 32'(o_ready), 32'(mode == M_RUN));
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!o_ready && n < 400) begin tick(); n++; end
      chk(name, 32'(n), 32'd256);
   endtask

   task automatic ld(input logic [7:0] a, input logic [15:0] d);
      i_ld_we = 1; i_ld_addr = a; i_ld_data = d; tick(); i_ld_we = 0;
   endtask

   task automatic fetch(input logic [31:0] a);
      i_req = 1; i_dir = a; tick(); i_req = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; i_ld_en = 0; i_ld_we = 0; i_req = 0;
      i_ld_addr = 0; i_ld_data = 0; i_dir = 0;
      repeat (3) tick();
      chk("rst_inst",  32'(o_inst),  32'hFFFF);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_valid", 32'(o_valid), 32'd0);

      rst_n = 1;
      i_req = 1; i_ld_en = 1; i_dir = 7;   // ignored during fill
      tick();
      i_req = 0; i_ld_en = 0;
      begin
         int n = 1;
         while (!o_ready && n < 400) begin tick(); n++; end
         chk("init_len", 32'(n), 32'd256);
      end

      fetch(7);
      chk("f7_valid", 32'(o_valid), 32'd1);
      chk("f7_inst",  32'(o_inst),  32'hFFFF);
      tick();
      chk("f7_pulse", 32'(o_valid), 32'd0);

      i_ld_en = 1; tick();
      chk("load_ready", 32'(o_ready), 32'd0);
      ld(3, 16'hB005);
      ld(4, 16'h0100);
      ld(255, 16'hC0DE);
      i_ld_en = 0; tick();
      chk("run_ready", 32'(o_ready), 32'd1);
      i_req = 1; i_dir = 3; tick();
      chk("f3_inst",  32'(o_inst),  32'hB005);
      chk("f3_valid", 32'(o_valid), 32'd1);
      i_dir = 4; tick(); i_req = 0;
      chk("f4_inst",  32'(o_inst),  32'h0100);
      chk("f4_valid", 32'(o_valid), 32'd1);
      tick();
      chk("hold_inst",  32'(o_inst),  32'h0100);
      chk("hold_valid", 32'(o_valid), 32'd0);

      fetch(300);
      chk("oor_inst",  32'(o_inst),  32'hFFFF);
      chk("oor_err",   32'(o_err),   32'd1);
      chk("oor_valid", 32'(o_valid), 32'd1);
      tick();
      chk("oor_pulse", 32'(o_err), 32'd0);

      i_ld_en = 1; i_req = 1; i_dir = 3; tick();
      i_req = 0;
      chk("prio_valid", 32'(o_valid), 32'd0);
      chk("prio_ready", 32'(o_ready), 32'd0);
      i_ld_en = 0; tick();

      fetch(255);
      chk("end_inst", 32'(o_inst), 32'hC0DE);
      chk("end_done", 32'(o_done), 32'd1);
      fetch(3);
      chk("done_valid", 32'(o_valid), 32'd0);
      chk("done_inst",  32'(o_inst),  32'hC0DE);
      i_ld_en = 1; tick();
      chk("done_clr", 32'(o_done), 32'd0);

      ld(3, 16'hAAAA);
      repeat (6) tick();
      rst_n = 0; #1;
      chk("arst_inst",  32'(o_inst),  32'hFFFF);
      chk("arst_ready", 32'(o_ready), 32'd0);
      chk("arst_done",  32'(o_done),  32'd0);
      i_ld_en = 0;
      repeat (2) tick();
      rst_n = 1;
      wait_ready("reinit_len");
      fetch(3);
      chk("reinit_f3", 32'(o_inst), 32'hFFFF);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
